// File: rtl/serial_link_partner_if.sv
// serial_link_partner_if: byte handshake and link-cable pins of the link partner
interface serial_link_partner_if;
    logic       mode_master;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck_in;
    logic       sck_out;
    logic       sck_oe;
    logic       sout_in;
    logic       sin_out;
    modport master (
        output mode_master, tx_data, tx_valid, sck_in, sout_in,
        input  tx_ready, rx_data, rx_valid, busy, sck_out, sck_oe, sin_out
    );
    modport slave (
        input  mode_master, tx_data, tx_valid, sck_in, sout_in,
        output tx_ready, rx_data, rx_valid, busy, sck_out, sck_oe, sin_out
    );
endinterface

// File: rtl/serial_link_partner.sv
// serial_link_partner: far-end Game Boy on the DMG link cable, one byte exchanged per transfer
module serial_link_partner #(
    parameter int HALF_PERIOD = 256,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    serial_link_partner_if.slave link
);
    localparam int HW = $clog2(HALF_PERIOD);
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, sout_sync;
    logic                   sck_prev, master;
    logic [6:0]             tx_sh, rx_sh;
    logic [3:0]             bit_cnt;
    logic [HW-1:0]          hp_cnt;
    logic                   s_rise, s_fall, hp_wrap, m_rise, m_fall, e_rise, e_fall, sample;
    assign s_rise  = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign s_fall  = ~sck_sync[SYNC_STAGES-1] & sck_prev;
    assign hp_wrap = hp_cnt == HW'(HALF_PERIOD - 1);
    assign m_rise  = hp_wrap & ~link.sck_out;
    assign m_fall  = hp_wrap & link.sck_out;
    assign e_rise  = master ? m_rise : s_rise;
    assign e_fall  = master ? m_fall : s_fall;
    assign sample  = sout_sync[SYNC_STAGES-1];
    // pin synchronizers plus the delayed copy used for SCK edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '1;
            sout_sync <= '1;
            sck_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], link.sck_in};
            sout_sync <= {sout_sync[SYNC_STAGES-2:0], link.sout_in};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
        end
    end
    // transfer FSM: own SCK generation in master mode, MSB-first shift on the selected SCK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            master        <= 1'b0;
            tx_sh         <= '1;
            rx_sh         <= '0;
            bit_cnt       <= '0;
            hp_cnt        <= '0;
            link.sin_out  <= 1'b1;
            link.sck_out  <= 1'b1;
            link.sck_oe   <= 1'b0;
            link.tx_ready <= 1'b1;
            link.rx_valid <= 1'b0;
            link.rx_data  <= 8'h00;
            link.busy     <= 1'b0;
        end else begin
            link.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (link.tx_valid) begin
                        tx_sh         <= link.tx_data[6:0];
                        rx_sh         <= '0;
                        bit_cnt       <= '0;
                        master        <= link.mode_master;
                        link.sin_out  <= link.tx_data[7];
                        link.tx_ready <= 1'b0;
                        link.busy     <= 1'b1;
                        state         <= ARMED;
                    end else if (!link.mode_master && s_fall) begin
                        tx_sh         <= '1;
                        rx_sh         <= '0;
                        bit_cnt       <= '0;
                        master        <= 1'b0;
                        link.sin_out  <= 1'b1;
                        link.tx_ready <= 1'b0;
                        link.busy     <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                ARMED: begin
                    if (master) begin
                        hp_cnt      <= '0;
                        link.sck_oe <= 1'b1;
                        state       <= SHIFT;
                    end else if (s_fall) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (master) hp_cnt <= hp_wrap ? '0 : hp_cnt + 1'b1;
                    if (master && hp_wrap) link.sck_out <= ~link.sck_out;
                    if (e_rise) begin
                        rx_sh   <= {rx_sh[5:0], sample};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            link.rx_data  <= {rx_sh, sample};
                            link.rx_valid <= 1'b1;
                            link.sin_out  <= 1'b1;
                            link.sck_out  <= 1'b1;
                            link.sck_oe   <= 1'b0;
                            link.busy     <= 1'b0;
                            hp_cnt        <= '0;
                            bit_cnt       <= '0;
                            state         <= DONE;
                        end
                    end else if (e_fall && bit_cnt != 4'd0) begin
                        tx_sh        <= {tx_sh[5:0], 1'b1};
                        link.sin_out <= tx_sh[6];
                    end
                end
                DONE: begin
                    link.tx_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_link_partner.sv
// tb_serial_link_partner: DMG-side model driving the partner in both clock modes, scoreboarded rx bytes
module tb_serial_link_partner;
    logic clk, rst;
    int checks = 0, errors = 0;
    logic [7:0] exp_rx[$];
    logic rv_prev = 1'b0;
    serial_link_partner_if link();
    serial_link_partner #(.HALF_PERIOD(4), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .link(link));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // monitor: every rx_valid pulse must match the oldest expected DMG byte
    always @(negedge clk) begin
        if (!rst && link.rx_valid) begin
            chk("rx_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) chk("rx_data", link.rx_data, exp_rx.pop_front());
            chk("rx_single_pulse", rv_prev, 0);
            chk("done_tx_ready", link.tx_ready, 0);
        end
        rv_prev <= link.rx_valid;
    end
    task automatic wait_ready();
        int n = 0;
        while (link.tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", link.tx_ready, 1);
    endtask
    task automatic load(input logic [7:0] d, input logic m);
        wait_ready();
        @(negedge clk);
        link.tx_data = d;
        link.mode_master = m;
        link.tx_valid = 1'b1;
        @(negedge clk);
        link.tx_valid = 1'b0;
    endtask
    // DMG on internal clock: shifts sout on its falling edge, samples sin on its rising edge
    task automatic dmg_int(input logic [7:0] b, input int hp, input int tog, output logic [7:0] got, output logic oe_seen);
        got = '0;
        oe_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            link.sck_in = 1'b0;
            link.sout_in = b[7-i];
            if (i == tog) link.mode_master = ~link.mode_master;
            repeat (hp) begin @(negedge clk); oe_seen |= link.sck_oe; end
            link.sck_in = 1'b1;
            got[7-i] = link.sin_out;
            repeat (hp) begin @(negedge clk); oe_seen |= link.sck_oe; end
        end
    endtask
    // DMG on external clock: watches the pulled-up SCK line, samples sin as held just before each rise
    task automatic dmg_ext(input logic [7:0] b, input int tog, input logic noise, output logic [7:0] got,
                           output int oe_cnt, output int nf, output logic first_fall, output int bits);
        logic prev, line, psin;
        prev = 1'b1;
        psin = link.sin_out;
        got = '0;
        oe_cnt = 0;
        nf = 0;
        first_fall = 1'b0;
        bits = 0;
        for (int t = 0; t < 400 && bits < 8; t++) begin
            @(negedge clk);
            line = link.sck_oe ? link.sck_out : 1'b1;
            if (link.sck_oe) oe_cnt++;
            if (prev && !line) begin
                if (nf == 0 && bits == 0) first_fall = 1'b1;
                nf++;
                link.sout_in = b[7-bits];
                if (bits == tog) link.mode_master = ~link.mode_master;
                if (noise) link.sck_in = ~link.sck_in;
            end
            if (!prev && line) begin
                got[7-bits] = psin;
                bits++;
            end
            prev = line;
            psin = link.sin_out;
        end
    endtask
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] got;
        logic oe_seen, ff;
        int oe_cnt, nf, bits;
        rst = 1'b1;
        link.mode_master = 1'b0;
        link.tx_data = '0;
        link.tx_valid = 1'b0;
        link.sck_in = 1'b1;
        link.sout_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sin_out", link.sin_out, 1);
        chk("rst_sck_out", link.sck_out, 1);
        chk("rst_sck_oe", link.sck_oe, 0);
        chk("rst_tx_ready", link.tx_ready, 1);
        chk("rst_rx_valid", link.rx_valid, 0);
        chk("rst_rx_data", link.rx_data, 0);
        chk("rst_busy", link.busy, 0);
        rst = 1'b0;
        load(8'hA5, 1'b0);
        chk("armed_busy", link.busy, 1);
        chk("armed_tx_ready", link.tx_ready, 0);
        chk("armed_sin_msb", link.sin_out, 1);
        exp_rx.push_back(8'h3C);
        dmg_int(8'h3C, 256, -1, got, oe_seen);
        chk("slave_sin_seq", got, 8'hA5);
        chk("slave_no_oe", oe_seen, 0);
        wait_ready();
        load(8'h81, 1'b1);
        exp_rx.push_back(8'hF0);
        dmg_ext(8'hF0, -1, 1'b0, got, oe_cnt, nf, ff, bits);
        chk("master_bits", bits, 8);
        chk("master_sin_seq", got, 8'h81);
        chk("master_oe_cycles", oe_cnt, 64);
        chk("master_falls", nf, 8);
        chk("master_first_fall", ff, 1);
        wait_ready();
        link.mode_master = 1'b0;
        exp_rx.push_back(8'h55);
        dmg_int(8'h55, 16, -1, got, oe_seen);
        chk("unarmed_sin", got, 8'hFF);
        load(8'hC0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            link.sck_in = 1'b0;
            repeat (16) @(negedge clk);
            link.sck_in = 1'b1;
            repeat (16) @(negedge clk);
        end
        chk("pre_rst_sin", link.sin_out, 0);
        rst = 1'b1;
        #1;
        chk("midrst_sin_out", link.sin_out, 1);
        chk("midrst_tx_ready", link.tx_ready, 1);
        chk("midrst_busy", link.busy, 0);
        chk("midrst_rx_data", link.rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        load(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("pre_rst_oe", link.sck_oe, 1);
        rst = 1'b1;
        #1;
        chk("midrst_sck_oe", link.sck_oe, 0);
        chk("midrst_sck_out", link.sck_out, 1);
        @(negedge clk);
        rst = 1'b0;
        load(8'h34, 1'b0);
        exp_rx.push_back(8'h12);
        dmg_int(8'h12, 16, -1, got, oe_seen);
        chk("post_rst_sin", got, 8'h34);
        load(8'h96, 1'b0);
        exp_rx.push_back(8'h69);
        dmg_int(8'h69, 16, 3, got, oe_seen);
        chk("slave_modechg_sin", got, 8'h96);
        chk("slave_modechg_oe", oe_seen, 0);
        load(8'h5A, 1'b1);
        exp_rx.push_back(8'hC3);
        dmg_ext(8'hC3, 3, 1'b1, got, oe_cnt, nf, ff, bits);
        chk("master_modechg_bits", bits, 8);
        chk("master_modechg_sin", got, 8'h5A);
        chk("master_modechg_oe", oe_cnt, 64);
        wait_ready();
        exp_rx.push_back(8'hE7);
        exp_rx.push_back(8'h3A);
        @(negedge clk);
        link.mode_master = 1'b1;
        link.tx_data = 8'h01;
        link.tx_valid = 1'b1;
        @(negedge clk);
        link.tx_data = 8'h02;
        dmg_ext(8'hE7, -1, 1'b0, got, oe_cnt, nf, ff, bits);
        chk("b2b_first_sin", got, 8'h01);
        chk("b2b_done_valid", link.rx_valid, 1);
        @(negedge clk);
        chk("b2b_idle_ready", link.tx_ready, 1);
        chk("b2b_idle_busy", link.busy, 0);
        @(negedge clk);
        chk("b2b_accept_busy", link.busy, 1);
        chk("b2b_accept_ready", link.tx_ready, 0);
        link.tx_valid = 1'b0;
        dmg_ext(8'h3A, -1, 1'b0, got, oe_cnt, nf, ff, bits);
        chk("b2b_second_sin", got, 8'h02);
        for (int k = 0; k < 25; k++) begin
            logic [7:0] t, d;
            logic m, a;
            t = 8'($urandom);
            d = 8'($urandom);
            m = 1'($urandom);
            a = m | 1'($urandom);
            exp_rx.push_back(d);
            if (m) begin
                load(t, 1'b1);
                dmg_ext(d, -1, 1'b0, got, oe_cnt, nf, ff, bits);
                chk("rnd_master_oe", oe_cnt, 64);
            end else begin
                if (a) load(t, 1'b0);
                else begin
                    wait_ready();
                    link.mode_master = 1'b0;
                end
                dmg_int(d, 8 + int'($urandom_range(0, 16)), -1, got, oe_seen);
            end
            chk("rnd_sin", got, a ? t : 8'hFF);
        end
        repeat (20) @(negedge clk);
        chk("rx_all_seen", exp_rx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
